// File: rtl/siaa_pkg.sv
// rtl/siaa_pkg.sv - shared types and constants for the SIAA fetch stage
package siaa_pkg;

    localparam int LUT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

    localparam logic [3:0] OP_BR    = 4'b1100;
    localparam logic [3:0] OP_J     = 4'b1101;
    localparam logic [2:0] IOP_HALT = 3'b110;

    // Branch/jump targets indexed by instr[7:4]; also read by the LUTA datapath.
    localparam logic [LUT_W-1:0] BRANCH_LUT [16] = '{
        10'd0,   10'd20,  10'd40,  10'd60,
        10'd80,  10'd100, 10'd120, 10'd140,
        10'd160, 10'd180, 10'd200, 10'd220,
        10'd240, 10'd260, 10'd280, 10'd300
    };

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch-target lookup
module branch_lut
    import siaa_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [3:0]      idx,
    output logic [PC_W-1:0] target
);

    assign target = PC_W'(BRANCH_LUT[idx]);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction fetch, branch resolve and run control
module fetch_unit
    import siaa_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  startAddr,
    input  logic [8:0]       imemData,
    input  logic             ctrlBranch,
    input  logic             brCond,
    input  logic             stall,
    output logic [PC_W-1:0]  imemAddr,
    output logic [8:0]       instr,
    output logic             valid,
    output logic             done,
    output logic [CNT_W-1:0] instCnt
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  target;
    logic             is_halt;
    logic             take;
    logic             running;

    branch_lut #(.PC_W(PC_W)) u_lut (
        .idx    (instr[7:4]),
        .target (target)
    );

    assign running  = (state_q == RUN);
    assign imemAddr = pc_q;
    assign instr    = running ? imemData : 9'h000;
    assign done     = (state_q == DONE);
    assign instCnt  = cnt_q;
    // Gated with reset so nothing downstream can write while reset is asserted.
    assign valid    = running & ~stall & ~reset;

    assign is_halt = instr[8] & (instr[2:0] == IOP_HALT);
    assign take    = ctrlBranch & ((instr[0] == OP_J[0]) | brCond);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = startAddr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Stall outranks both HALT and jump: the instruction is simply held.
                if (!stall) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (is_halt) begin
                        state_d = DONE;
                    end else if (take) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [8:0] I_ADD  = 9'h010;
    localparam logic [8:0] I_BR2  = 9'h02C;
    localparam logic [8:0] I_J2   = 9'h02D;
    localparam logic [8:0] I_HALT = 9'h106;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  startAddr;
    logic [8:0]  imemData;
    logic        ctrlBranch;
    logic        brCond;
    logic        stall;
    logic [9:0]  imemAddr;
    logic [8:0]  instr;
    logic        valid;
    logic        done;
    logic [15:0] instCnt;

    logic [8:0] rom [1024];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imemData   = rom[imemAddr];
    // Stand-in decoder: BR/J are R-type (instr[8]=0) with rOp 110x.
    assign ctrlBranch = ~instr[8] & (instr[3:1] == 3'b110);

    fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .startAddr  (startAddr),
        .imemData   (imemData),
        .ctrlBranch (ctrlBranch),
        .brCond     (brCond),
        .stall      (stall),
        .imemAddr   (imemAddr),
        .instr      (instr),
        .valid      (valid),
        .done       (done),
        .instCnt    (instCnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] addr);
        start     = 1'b1;
        startAddr = addr;
        step();
        start     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        brCond = 1'b0;
        stall  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({imemAddr, instr, valid, done, instCnt} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%0d instr=%h valid=%b done=%b cnt=%0d want all 0",
                     imemAddr, instr, valid, done, instCnt);
        end
        reset = 1'b0;
        step();
        step();
        n_tests++;
        if (valid !== 1'b0 || imemAddr !== 10'd0) begin
            n_fail++;
            $display("FAIL idle_hold: valid=%b addr=%0d want 0 0", valid, imemAddr);
        end
    endtask

    task automatic test_straight_line();
        pulse_start(10'd3);
        for (int a = 3; a <= 7; a++) begin
            n_tests++;
            if (imemAddr !== 10'(a) || valid !== 1'b1 || instCnt !== 16'(a - 3)) begin
                n_fail++;
                $display("FAIL straight_pc%0d: addr=%0d valid=%b cnt=%0d want %0d 1 %0d",
                         a, imemAddr, valid, instCnt, a, a - 3);
            end
            if (a != 7) step();
        end
        n_tests++;
        if (instr !== I_HALT) begin
            n_fail++;
            $display("FAIL halt_instr: got %h want %h", instr, I_HALT);
        end
        step();
        n_tests++;
        if (done !== 1'b1 || instCnt !== 16'd5 || valid !== 1'b0 || imemAddr !== 10'd7 || instr !== 9'h000) begin
            n_fail++;
            $display("FAIL halt_done: done=%b cnt=%0d valid=%b addr=%0d instr=%h want 1 5 0 7 000",
                     done, instCnt, valid, imemAddr, instr);
        end
        step();
        step();
        n_tests++;
        if (done !== 1'b1 || imemAddr !== 10'd7) begin
            n_fail++;
            $display("FAIL done_frozen: done=%b addr=%0d want 1 7", done, imemAddr);
        end
    endtask

    task automatic test_restart_and_reset();
        start     = 1'b1;
        startAddr = 10'd0;
        #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_until_edge: done=%b want 1", done);
        end
        step();
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || imemAddr !== 10'd0 || instCnt !== 16'd0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: done=%b addr=%0d cnt=%0d valid=%b want 0 0 0 1",
                     done, imemAddr, instCnt, valid);
        end
        step();
        pulse_start(10'd30);
        n_tests++;
        if (imemAddr !== 10'd2 || instCnt !== 16'd2) begin
            n_fail++;
            $display("FAIL start_in_run: addr=%0d cnt=%0d want 2 2", imemAddr, instCnt);
        end
        step();
        step();
        step();
        n_tests++;
        if (imemAddr !== 10'd5 || instCnt !== 16'd5) begin
            n_fail++;
            $display("FAIL pre_reset_pc: addr=%0d cnt=%0d want 5 5", imemAddr, instCnt);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (imemAddr !== 10'd0 || valid !== 1'b0 || done !== 1'b0 || instCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: addr=%0d valid=%b done=%b cnt=%0d want 0 0 0 0",
                     imemAddr, valid, done, instCnt);
        end
        step();
        reset = 1'b0;
        step();
        step();
        n_tests++;
        if (valid !== 1'b0 || imemAddr !== 10'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b addr=%0d done=%b want 0 0 0", valid, imemAddr, done);
        end
    endtask

    task automatic test_branches();
        brCond = 1'b0;
        pulse_start(10'd15);
        step();
        n_tests++;
        if (imemAddr !== 10'd40) begin
            n_fail++;
            $display("FAIL j_cond0: addr=%0d want 40", imemAddr);
        end
        do_reset();
        brCond = 1'b1;
        pulse_start(10'd15);
        step();
        n_tests++;
        if (imemAddr !== 10'd40) begin
            n_fail++;
            $display("FAIL j_cond1: addr=%0d want 40", imemAddr);
        end
        do_reset();
        pulse_start(10'd20);
        step();
        n_tests++;
        if (imemAddr !== 10'd21 || instCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL br_not_taken: addr=%0d cnt=%0d want 21 1", imemAddr, instCnt);
        end
        do_reset();
        brCond = 1'b1;
        pulse_start(10'd20);
        step();
        n_tests++;
        if (imemAddr !== 10'd40) begin
            n_fail++;
            $display("FAIL br_taken: addr=%0d want 40", imemAddr);
        end
        do_reset();
    endtask

    task automatic test_stall();
        pulse_start(10'd10);
        stall = 1'b1;
        #1;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_valid: valid=%b want 0", valid);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (imemAddr !== 10'd10 || valid !== 1'b0 || instCnt !== 16'd0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: addr=%0d valid=%b cnt=%0d want 10 0 0",
                         c, imemAddr, valid, instCnt);
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (imemAddr !== 10'd40 || instCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_release_jump: addr=%0d cnt=%0d want 40 1", imemAddr, instCnt);
        end
        do_reset();
        pulse_start(10'd7);
        stall = 1'b1;
        step();
        n_tests++;
        if (done !== 1'b0 || imemAddr !== 10'd7) begin
            n_fail++;
            $display("FAIL stalled_halt: done=%b addr=%0d want 0 7", done, imemAddr);
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b1 || instCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_after_stall: done=%b cnt=%0d want 1 1", done, instCnt);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        pulse_start(10'd1023);
        n_tests++;
        if (imemAddr !== 10'd1023) begin
            n_fail++;
            $display("FAIL wrap_start: addr=%0d want 1023", imemAddr);
        end
        step();
        n_tests++;
        if (imemAddr !== 10'd0 || instCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap: addr=%0d cnt=%0d want 0 1", imemAddr, instCnt);
        end
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = I_ADD;
        rom[7]  = I_HALT;
        rom[10] = I_J2;
        rom[15] = I_J2;
        rom[20] = I_BR2;
        reset     = 1'b1;
        start     = 1'b0;
        startAddr = 10'd0;
        brCond    = 1'b0;
        stall     = 1'b0;

        test_reset();
        test_straight_line();
        test_restart_and_reset();
        test_branches();
        test_stall();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the SIAA single-cycle processor. It owns the program counter, addresses the combinational instruction memory, and presents the 9-bit instruction to the control decoder. It resolves BR/J using the decoder's branch strobe and a 16-entry branch-target LUT. A start/done handshake brackets each program run, and the unit counts executed instructions.

## Interface
- PC_W, 10, program counter / instruction-memory address width
- CNT_W, 16, width of the executed-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run at `startAddr`
- startAddr  in  PC_W  first PC of the run
- imemData  in  9  instruction at `imemAddr` (combinational ROM)
- ctrlBranch  in  1  branch strobe from the control decoder for the current instruction
- brCond  in  1  condition flag for BR (R0 == 0 result from the EQ/SLT datapath)
- stall  in  1  hold the current PC this cycle
- imemAddr  out  PC_W  equals PC
- instr  out  9  instruction to the decoder; `imemData` in RUN, 9'h000 otherwise
- valid  out  1  instruction is live; downstream gates regWrite/regSet/memWrite with it
- done  out  1  run complete
- instCnt  out  CNT_W  number of retired instructions in the current run

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - `start` loads PC ← `startAddr`, clears `instCnt`, and moves to RUN.
- RUN:
  - HALT is instr[8]=1 with instr[2:0]=3'b110, the unused I-type slot. It retires, increments `instCnt`, leaves PC unchanged, and moves to DONE.
  - Jump when `ctrlBranch` is high and either instr[0]=1 (J, rOp 1101) or `brCond`=1 (BR, rOp 1100).
  - Target is `branch_lut[instr[7:4]]`.
  - Next PC:
    - `stall`: PC unchanged.
    - jump: target.
    - otherwise: PC+1, mod 2^PC_W (wraps to 0).
- `valid` = (state==RUN) & ~`stall`.
- `instCnt` increments on every cycle where `valid` is high and saturates at all-ones.
- DONE:
  - `done`=1 and PC is frozen.
  - `start` begins a new run exactly as from IDLE.
- `start` while in RUN is ignored.
- `stall` has no effect outside RUN. In RUN it takes priority over both jump and HALT: a stalled HALT is not recognised until the cycle it is unstalled.
- Reset mid-run forces IDLE immediately. No write enable may be qualified by `valid` during reset.

## Timing
- Reset values: PC=0, `imemAddr`=0, state=IDLE, `instr`=0, `valid`=0, `done`=0, `instCnt`=0.
- `start` at edge n: first instruction is live (`valid`=1, `imemAddr`=`startAddr`) in cycle n+1.
- Fetch-to-decode latency: 0 cycles. `instr` is combinational from `imemData`.
- Branch resolution has 0 penalty: the target is fetched in the cycle after the branch.
- HALT retired at edge h gives `done`=1 from cycle h+1.
- `done` stays high until the edge that samples `start`, and drops in the next cycle.

## Structure
- Package `siaa_pkg` holds:
  - state enum `fetch_state_t` (IDLE/RUN/DONE);
  - opcode constants OP_BR=4'b1100, OP_J=4'b1101, IOP_HALT=3'b110;
  - branch-target LUT contents as a `localparam` array of 16 × PC_W.
- Sub-module `branch_lut`: combinational, 4-bit index in, PC_W-bit target out, read from the package constant. The processor's LUTA path reuses it.

## Test plan
- Reset mid-run: assert `reset` at PC=5 → same cycle PC=0, `valid`=0, `done`=0, `instCnt`=0; IDLE until `start`.
- Straight line: `start` with `startAddr`=3, ROM 3..6 = ADD, and HALT at 7 → `imemAddr` steps 3,4,5,6,7; `done`=1 the cycle after 7; `instCnt`=5.
- Branches, with LUT[2]=40:
  - J with instr[7:4]=2 → next PC=40 regardless of `brCond`;
  - BR with `brCond`=0 → PC+1;
  - BR with `brCond`=1 → 40.
- Stall: `stall` held high 3 cycles at PC=10 → PC stays 10, `valid`=0, `instCnt` unchanged; when released, a jump in the same instruction is honoured.
- Wrap: `startAddr`=1023 with no branch → next `imemAddr`=0.
- Start handling:
  - `start` during RUN has no effect on PC or count.
  - `start` in DONE with `startAddr`=0 → `done` drops, run restarts at 0, `instCnt` cleared.
